large_mul_seq: RTL

Parametrised, digit-serial unsigned multiplier that computes the full 2·WIDTH-bit product of two WIDTH-bit operands over WIDTH/DIGIT cycles. It succeeds the fixed 1024-bit parallel multiplier and trades area for latency through the DIGIT parameter. Operands enter and the product leaves on valid/ready handshakes, so the block sits directly in the large-number datapath between the operand source and the result consumer.

---
 rtl/large_mul_seq_pkg.sv | 43 ++++
 rtl/large_mul_seq_mac_row.sv | 34 +++
 rtl/large_mul_seq.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/large_mul_seq_pkg.sv
// -----------------------------------------------------------------------------
// large_mul_pkg
// Shared definitions for the digit-serial multiplier large_mul_seq:
//   - state_e        : controller states (IDLE, BUSY, DONE)
//   - calc_ndig      : number of DIGIT-bit digits in a WIDTH-bit multiplier
//   - calc_cnt_w     : digit counter width, clog2(NDIG) with a floor of 1
//   - geometry_ok    : elaboration-time legality of the WIDTH/DIGIT pair
// -----------------------------------------------------------------------------
package large_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Digits per operand; a zero DIGIT is rejected by geometry_ok, so avoid the
  // divide-by-zero here and let that check report it.
  function automatic int calc_ndig(input int width, input int digit);
    if (digit < 1) begin
      return 1;
    end else begin
      return width / digit;
    end
  endfunction

  // Counter only needs to reach NDIG-1; a single-digit build still gets one bit.
  function automatic int calc_cnt_w(input int width, input int digit);
    int n;
    n = calc_ndig(width, digit);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // WIDTH must split into whole digits and a digit cannot exceed the operand.
  function automatic bit geometry_ok(input int width, input int digit);
    return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/large_mul_seq_mac_row.sv
// -----------------------------------------------------------------------------
// large_mul_mac_row
// Combinational multiply-accumulate row: sum_o = acc_i + a_i * d_i, all in
// 2*WIDTH bits. a_i is the already-shifted multiplicand, d_i the current
// multiplier digit. This row is the critical path of large_mul_seq.
// Ports:
//   acc_i  [2*WIDTH-1:0]  running accumulator
//   a_i    [2*WIDTH-1:0]  multiplicand aligned to the current digit position
//   d_i    [DIGIT-1:0]    multiplier digit
//   sum_o  [2*WIDTH-1:0]  updated accumulator (carry out of the MSB dropped)
// -----------------------------------------------------------------------------
module large_mul_mac_row #(
  parameter int WIDTH = 1024,
  parameter int DIGIT = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] a_i,
  input  logic [DIGIT-1:0]   d_i,
  output logic [2*WIDTH-1:0] sum_o
);

  logic [2*WIDTH-1:0] d_ext_s;
  logic [2*WIDTH-1:0] pp_s;

  // Widen the digit, form the partial product and fold it into the accumulator.
  // The exact product of the operands fits in 2*WIDTH bits, so truncating both
  // the partial product and the sum never loses a bit of the final result.
  always_comb begin
    d_ext_s = {{(2*WIDTH-DIGIT){1'b0}}, d_i};
    pp_s    = a_i * d_ext_s;
    sum_o   = acc_i + pp_s;
  end

endmodule

// File: rtl/large_mul_seq.sv
// -----------------------------------------------------------------------------
// large_mul_seq
// Digit-serial unsigned multiplier producing the exact 2*WIDTH-bit product of
// two WIDTH-bit operands, consuming DIGIT multiplier bits per cycle
// (NDIG = WIDTH/DIGIT cycles per product).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid            in_ready   block accepts operands (IDLE)
//   in_a       multiplicand [WIDTH-1:0]  in_b       multiplier [WIDTH-1:0]
//   out_valid  product valid (DONE)      out_ready  consumer takes product
//   out_p      product [2*WIDTH-1:0]     busy       computation in progress
//
// Build option:
//   LARGE_MUL_SEQ_EARLY_EXIT_EN - when defined, BUSY ends as soon as the
//   remaining multiplier is zero, so latency follows the highest nonzero digit
//   of in_b (highest index + 2, or 1 for a zero multiplier). Products are the
//   same in both builds.
// -----------------------------------------------------------------------------
module large_mul_seq
  import large_mul_pkg::*;
#(
  parameter int WIDTH = 1024,
  parameter int DIGIT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 busy
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(WIDTH, DIGIT);

  if (!geometry_ok(WIDTH, DIGIT)) begin : g_bad_geometry
    $error("large_mul_seq: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
  end

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mac_sum_s;

`ifdef LARGE_MUL_SEQ_EARLY_EXIT_EN
  logic                 b_zero_s;
`else
  logic                 last_dig_s;
`endif

  large_mul_mac_row #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) u_mac_row (
    .acc_i (acc_q),
    .a_i   (a_q),
    .d_i   (b_q[DIGIT-1:0]),
    .sum_o (mac_sum_s)
  );

`ifdef LARGE_MUL_SEQ_EARLY_EXIT_EN
  // Remaining multiplier exhausted: nothing more can be added to acc.
  always_comb begin
    b_zero_s = (b_q == {WIDTH{1'b0}});
  end
`else
  // The digit being consumed this cycle is the last one.
  always_comb begin
    last_dig_s = (cnt_q == CNT_W'(NDIG - 1));
  end
`endif

  // Next-state and datapath update for the IDLE/BUSY/DONE controller.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{WIDTH{1'b0}}, in_a};
          b_d     = in_b;
          acc_d   = {(2*WIDTH){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end

      BUSY: begin
`ifdef LARGE_MUL_SEQ_EARLY_EXIT_EN
        // Exit is driven only by the zero detect: B is fully shifted out after
        // NDIG digits at the latest, so the counter never needs to stop BUSY.
        if (b_zero_s) begin
          state_d = DONE;
        end else begin
          acc_d   = mac_sum_s;
          a_d     = a_q << DIGIT;
          b_d     = b_q >> DIGIT;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = BUSY;
        end
`else
        acc_d = mac_sum_s;
        a_d   = a_q << DIGIT;
        b_d   = b_q >> DIGIT;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_dig_s) begin
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
`endif
      end

      DONE: begin
        // acc is frozen here, which keeps out_p stable under back-pressure.
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, operand and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= {(2*WIDTH){1'b0}};
      b_q     <= {WIDTH{1'b0}};
      acc_q   <= {(2*WIDTH){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode from the state register; rst forces every output low in
  // the same cycle so a block in reset never advertises ready or valid.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    out_p     = {(2*WIDTH){1'b0}};
    if (rst) begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      out_p     = {(2*WIDTH){1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          in_ready = 1'b1;
        end
        BUSY: begin
          busy = 1'b1;
        end
        DONE: begin
          out_valid = 1'b1;
          out_p     = acc_q;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

endmodule
